execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the five-stage RISC-V pipeline. It holds the ID/EX pipeline register, selects forwarded operands, runs the ALU on the 3-bit ALU control code produced in Decode, and resolves branch/jump redirection. It also holds the EX/MEM pipeline register that feeds the Memory stage. The Decode-side decoders feed it; the hazard unit drives its forwarding and flush inputs.

## Interface
- WIDTH, 32, datapath width (PC, operands, immediate, result)
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears both pipeline registers
- RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  Decode control bits
- ResultSrcD  in  2  result mux select for Writeback
- ALUControlD  in  3  ALU code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- RD1D, RD2D, ImmExtD, PCD, PCPlus4D  in  WIDTH each  Decode operands
- Rs1D, Rs2D, RdD  in  5 each  register indices
- FlushE  in  1  from hazard unit; turns the ID/EX load into a bubble
- ForwardAE, ForwardBE  in  2 each  forwarding selects for SrcA and for the rs2 operand
- ALUResultM, ResultW  in  WIDTH each  forwarded values from Memory and Writeback
- Rs1E, Rs2E, RdE  out  5 each  ID/EX indices, to hazard unit
- ResultSrcE0  out  1  ID/EX ResultSrc[0] (load-use detection)
- PCSrcE  out  1  redirect taken
- PCTargetE  out  WIDTH  redirect target
- RegWriteM, MemWriteM  out  1 each  EX/MEM control
- ResultSrcM  out  2  EX/MEM result select
- ALUResultM_q, WriteDataM, PCPlus4M  out  WIDTH each  EX/MEM data
- RdM  out  5  EX/MEM destination

## Operation
- ID/EX register: on each rising edge, if FlushE=1, all control fields (RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl) and all data/index fields load 0. Otherwise every D-input is captured. There is no E-stage stall.
- SrcA forwarding on ForwardAE:
  - 00 → RD1E
  - 10 → ALUResultM
  - 01 → ResultW
  - 11 → RD1E
- The rs2 operand (WriteDataE) uses the same encoding on ForwardBE with RD2E.
- SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALU, all arithmetic modulo 2^WIDTH with overflow ignored:
  - add: SrcA+SrcB
  - sub: SrcA−SrcB
  - and, or, xor: bitwise
  - slt: 1 if SrcA < SrcB signed, else 0. Computed from the subtraction as sign XOR signed-overflow.
  - codes 110/111: result 0
- ZeroE = (ALUResultE == 0).
- PCSrcE = (BranchE & ZeroE) | JumpE. Branch is beq-style; Decode issues ALUControl=001.
- PCTargetE = PCE + ImmExtE, wrap-around.
- EX/MEM register: loads RegWriteE, MemWriteE, ResultSrcE, ALUResultE, WriteDataE, PCPlus4E and RdE every rising edge unconditionally.
- Both Memory-side ALU result ports are named ALUResultM. The output is registered as ALUResultM_q and the parent connects it to the ALUResultM input loop.

## Timing
- reset low, at any time including mid-instruction: all ID/EX and EX/MEM fields clear to 0 immediately. All outputs then read 0, including PCSrcE=0 and PCTargetE=0.
- First capture after reset deasserts is on the next rising edge.
- Latency: a Decode instruction presented at edge N is in E during cycle N→N+1. PCSrcE/PCTargetE are valid combinationally in that cycle. The M outputs are valid after edge N+1.
- PCSrcE is combinational from E-state and forwarding inputs. The consumer flushes D/E on it; FlushE=1 on the same edge as a valid D-input discards that input.
- Flushed bubble: ALU computes 0+0, ZeroE=1 but BranchE=0, so PCSrcE=0, and the bubble propagates to M with RegWriteM=0 and MemWriteM=0.

## Test plan
- Reset: drive reset=0 mid-stream with RegWriteD=1, RdD=5 → all outputs 0 at once. Release reset and present add 3+4, RdD=5 → after one edge RdE=5; after the next edge ALUResultM_q=7, RdM=5, RegWriteM=1.
- ALU codes with RD1=0xFFFF_FFFE, RD2=0x0000_0003, ALUSrc=0:
  - add → 0x0000_0001
  - sub → 0xFFFF_FFFB
  - and → 0x0000_0002
  - or → 0xFFFF_FFFF
  - xor → 0xFFFF_FFFD
  - slt → 1
- slt overflow: SrcA=0x8000_0000, SrcB=0x0000_0001 → 1. With the operands swapped → 0.
- Forwarding: RD1D=1, ALUResultM=0x10, ResultW=0x20, SrcB=2:
  - ForwardAE=10 → 0x12
  - ForwardAE=01 → 0x22
  - ForwardAE=11 → 3
  - ForwardBE=10 with MemWriteD=1 → WriteDataM=0x10
- Branch/jump:
  - BranchD=1, sub with equal operands, PCD=0x100, ImmExtD=0xFFFF_FFF8 → PCSrcE=1, PCTargetE=0xF8
  - Unequal operands → PCSrcE=0
  - JumpD=1 → PCSrcE=1 regardless of operands
- Flush: FlushE=1 with RegWriteD=1, JumpD=1 → next cycle PCSrcE=0, RdE=0; one edge later RegWriteM=0, MemWriteM=0.

Source files
------------

// File: rtl/execute_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch/jump resolution, EX/MEM register.
// Latency: D inputs reach E one edge after capture; M outputs one edge after that. PCSrcE/PCTargetE are combinational from E.
// Backpressure: none; the stage never stalls. FlushE turns the ID/EX load into a bubble.

module execute_fwd_mux #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] reg_val,
    input  logic [WIDTH-1:0] alu_m,
    input  logic [WIDTH-1:0] res_w,
    output logic [WIDTH-1:0] out_val
);
    // Forwarding operand select: 10 picks Memory, 01 picks Writeback, 00/11 keep the register value.
    // Latency: combinational.
    // Backpressure: none.
    always_comb begin
        out_val = reg_val;
        case (sel)
            2'b10:   out_val = alu_m;
            2'b01:   out_val = res_w;
            default: out_val = reg_val;
        endcase
    end
endmodule

module execute_alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH-1:0] result,
    output logic             zero
);
    // Integer ALU: add, sub, and, or, xor, slt; unused codes yield 0.
    // Latency: combinational.
    // Backpressure: none.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [WIDTH-1:0] diff;
    logic             sub_ovf;
    logic             less;

    // Signed less-than reuses the subtractor: sign of the difference, corrected on overflow.
    assign diff    = src_a - src_b;
    assign sub_ovf = (src_a[WIDTH-1] ^ src_b[WIDTH-1]) & (diff[WIDTH-1] ^ src_a[WIDTH-1]);
    assign less    = diff[WIDTH-1] ^ sub_ovf;

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = src_a + src_b;
            ALU_SUB: result = diff;
            ALU_AND: result = src_a & src_b;
            ALU_OR:  result = src_a | src_b;
            ALU_XOR: result = src_a ^ src_b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, less};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] ImmExtD,
    input  logic [WIDTH-1:0] PCD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             FlushE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] ResultW,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             ResultSrcE0,
    output logic             PCSrcE,
    output logic [WIDTH-1:0] PCTargetE,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [1:0]       ResultSrcM,
    output logic [WIDTH-1:0] ALUResultM_q,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [WIDTH-1:0] PCPlus4M,
    output logic [4:0]       RdM
);
    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic             jump;
        logic             branch;
        logic             alu_src;
        logic [1:0]       result_src;
        logic [2:0]       alu_control;
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] imm_ext;
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] pc_plus4;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
    } idex_t;

    typedef struct packed {
        logic             reg_write;
        logic             mem_write;
        logic [1:0]       result_src;
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] write_data;
        logic [WIDTH-1:0] pc_plus4;
        logic [4:0]       rd;
    } exmem_t;

    idex_t            idex_d;
    idex_t            idex_q;
    exmem_t           exmem_d;
    exmem_t           exmem_q;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] write_data_e;
    logic [WIDTH-1:0] alu_result_e;
    logic             zero_e;

    always_comb begin
        idex_d             = '0;
        idex_d.reg_write   = RegWriteD;
        idex_d.mem_write   = MemWriteD;
        idex_d.jump        = JumpD;
        idex_d.branch      = BranchD;
        idex_d.alu_src     = ALUSrcD;
        idex_d.result_src  = ResultSrcD;
        idex_d.alu_control = ALUControlD;
        idex_d.rd1         = RD1D;
        idex_d.rd2         = RD2D;
        idex_d.imm_ext     = ImmExtD;
        idex_d.pc          = PCD;
        idex_d.pc_plus4    = PCPlus4D;
        idex_d.rs1         = Rs1D;
        idex_d.rs2         = Rs2D;
        idex_d.rd          = RdD;
    end

    // A flush loads an all-zero bubble: it can neither write nor redirect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    execute_fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
        .sel     (ForwardAE),
        .reg_val (idex_q.rd1),
        .alu_m   (ALUResultM),
        .res_w   (ResultW),
        .out_val (src_a)
    );

    execute_fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
        .sel     (ForwardBE),
        .reg_val (idex_q.rd2),
        .alu_m   (ALUResultM),
        .res_w   (ResultW),
        .out_val (write_data_e)
    );

    assign src_b = idex_q.alu_src ? idex_q.imm_ext : write_data_e;

    execute_alu #(.WIDTH(WIDTH)) u_alu (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (idex_q.alu_control),
        .result      (alu_result_e),
        .zero        (zero_e)
    );

    // Branches are beq-style: Decode issues a subtract, so equality shows up as a zero result.
    assign PCSrcE    = (idex_q.branch & zero_e) | idex_q.jump;
    assign PCTargetE = idex_q.pc + idex_q.imm_ext;

    always_comb begin
        exmem_d            = '0;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.result_src = idex_q.result_src;
        exmem_d.alu_result = alu_result_e;
        exmem_d.write_data = write_data_e;
        exmem_d.pc_plus4   = idex_q.pc_plus4;
        exmem_d.rd         = idex_q.rd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign Rs1E         = idex_q.rs1;
    assign Rs2E         = idex_q.rs2;
    assign RdE          = idex_q.rd;
    assign ResultSrcE0  = idex_q.result_src[0];
    assign RegWriteM    = exmem_q.reg_write;
    assign MemWriteM    = exmem_q.mem_write;
    assign ResultSrcM   = exmem_q.result_src;
    assign ALUResultM_q = exmem_q.alu_result;
    assign WriteDataM   = exmem_q.write_data;
    assign PCPlus4M     = exmem_q.pc_plus4;
    assign RdM          = exmem_q.rd;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus a randomized back-to-back stream
// checked against an instruction-level reference model.
module tb_execute_stage;
    localparam int W = 32;

    typedef struct packed {
        logic         rw;
        logic         mw;
        logic         jump;
        logic         branch;
        logic         alusrc;
        logic [1:0]   rsrc;
        logic [2:0]   aluc;
        logic [W-1:0] rd1;
        logic [W-1:0] rd2;
        logic [W-1:0] imm;
        logic [W-1:0] pc;
        logic [W-1:0] pc4;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
    } instr_t;

    typedef struct packed {
        logic         rw;
        logic         mw;
        logic [1:0]   rsrc;
        logic [W-1:0] alu;
        logic [W-1:0] wd;
        logic [W-1:0] pc4;
        logic [4:0]   rd;
    } mexp_t;

    logic         clk;
    logic         reset;
    instr_t       din;
    logic         FlushE;
    logic [1:0]   ForwardAE;
    logic [1:0]   ForwardBE;
    logic [W-1:0] ALUResultM;
    logic [W-1:0] ResultW;
    logic [4:0]   Rs1E, Rs2E, RdE, RdM;
    logic         ResultSrcE0, PCSrcE, RegWriteM, MemWriteM;
    logic [W-1:0] PCTargetE, ALUResultM_q, WriteDataM, PCPlus4M;
    logic [1:0]   ResultSrcM;
    logic [153:0] all_out;

    int total = 0;
    int bad = 0;

    execute_stage #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .RegWriteD    (din.rw),
        .MemWriteD    (din.mw),
        .JumpD        (din.jump),
        .BranchD      (din.branch),
        .ALUSrcD      (din.alusrc),
        .ResultSrcD   (din.rsrc),
        .ALUControlD  (din.aluc),
        .RD1D         (din.rd1),
        .RD2D         (din.rd2),
        .ImmExtD      (din.imm),
        .PCD          (din.pc),
        .PCPlus4D     (din.pc4),
        .Rs1D         (din.rs1),
        .Rs2D         (din.rs2),
        .RdD          (din.rd),
        .FlushE       (FlushE),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .ALUResultM   (ALUResultM),
        .ResultW      (ResultW),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .ResultSrcE0  (ResultSrcE0),
        .PCSrcE       (PCSrcE),
        .PCTargetE    (PCTargetE),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .ResultSrcM   (ResultSrcM),
        .ALUResultM_q (ALUResultM_q),
        .WriteDataM   (WriteDataM),
        .PCPlus4M     (PCPlus4M),
        .RdM          (RdM)
    );

    assign all_out = {Rs1E, Rs2E, RdE, ResultSrcE0, PCSrcE, PCTargetE, RegWriteM, MemWriteM,
                      ResultSrcM, ALUResultM_q, WriteDataM, PCPlus4M, RdM};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: operand selection and ALU semantics stated directly.
    function automatic logic [W-1:0] fwd_val(input logic [1:0] sel, input logic [W-1:0] r,
                                              input logic [W-1:0] m, input logic [W-1:0] w);
        case (sel)
            2'b10:   return m;
            2'b01:   return w;
            default: return r;
        endcase
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] c);
        case (c)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic clear_inputs();
        din        = '0;
        FlushE     = 1'b0;
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        ALUResultM = '0;
        ResultW    = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #3;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_initial: outputs=%h required=0", all_out);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        din.rw = 1'b1; din.jump = 1'b1; din.rd = 5'd5; din.rd1 = 32'd3; din.rd2 = 32'd4;
        din.pc = 32'h40; din.imm = 32'd4; din.pc4 = 32'h44;
        step();
        step();
        total++;
        if (RdM !== 5'd5 || PCSrcE !== 1'b1) begin
            bad++;
            $display("FAIL reset_prefill: RdM=%0d PCSrcE=%b required 5/1", RdM, PCSrcE);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_midstream: outputs=%h required=0", all_out);
        end
        din = '0;
        din.rw = 1'b1; din.rd = 5'd5; din.rd1 = 32'd3; din.rd2 = 32'd4;
        #1;
        reset = 1'b1;
        step();
        total++;
        if (RdE !== 5'd5) begin
            bad++;
            $display("FAIL reset_first_capture: RdE=%0d required=5", RdE);
        end
        step();
        total++;
        if (ALUResultM_q !== 32'd7 || RdM !== 5'd5 || RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_result: alu=%h rd=%0d rw=%b required 7/5/1",
                     ALUResultM_q, RdM, RegWriteM);
        end
    endtask

    task automatic test_alu_codes();
        logic [W-1:0] exp_tab [8];
        exp_tab = '{32'h0000_0001, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFF,
                    32'hFFFF_FFFD, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000};
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            din.rd1 = 32'hFFFF_FFFE;
            din.rd2 = 32'h0000_0003;
            din.aluc = 3'(c);
            step();
            step();
            total++;
            if (ALUResultM_q !== exp_tab[c]) begin
                bad++;
                $display("FAIL alu_code_%0d: got=%h required=%h", c, ALUResultM_q, exp_tab[c]);
            end
        end
    endtask

    task automatic test_slt_overflow();
        logic [W-1:0] ops [2];
        ops = '{32'h8000_0000, 32'h0000_0001};
        for (int k = 0; k < 2; k++) begin
            clear_inputs();
            din.aluc = 3'b101;
            din.rd1 = ops[k];
            din.rd2 = ops[1-k];
            step();
            step();
            total++;
            if (ALUResultM_q !== ((k == 0) ? 32'd1 : 32'd0)) begin
                bad++;
                $display("FAIL slt_overflow_%0d: got=%h required=%0d", k, ALUResultM_q,
                         (k == 0) ? 1 : 0);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [W-1:0] exp_a [4];
        exp_a = '{32'h3, 32'h22, 32'h12, 32'h3};
        for (int s = 0; s < 4; s++) begin
            clear_inputs();
            din.rd1 = 32'd1; din.rd2 = 32'h99; din.alusrc = 1'b1; din.imm = 32'd2;
            ALUResultM = 32'h10; ResultW = 32'h20;
            ForwardAE = 2'(s);
            step();
            step();
            total++;
            if (ALUResultM_q !== exp_a[s]) begin
                bad++;
                $display("FAIL fwd_a_sel%0d: got=%h required=%h", s, ALUResultM_q, exp_a[s]);
            end
        end
        clear_inputs();
        din.rd1 = 32'd1; din.rd2 = 32'h99; din.alusrc = 1'b1; din.imm = 32'd2; din.mw = 1'b1;
        ALUResultM = 32'h10; ResultW = 32'h20; ForwardBE = 2'b10;
        step();
        step();
        total++;
        if (WriteDataM !== 32'h10 || MemWriteM !== 1'b1 || ALUResultM_q !== 32'd3) begin
            bad++;
            $display("FAIL fwd_b_mem: wd=%h mw=%b alu=%h required 10/1/3",
                     WriteDataM, MemWriteM, ALUResultM_q);
        end
    endtask

    task automatic test_branch_jump();
        clear_inputs();
        din.branch = 1'b1; din.aluc = 3'b001; din.rd1 = 32'h55; din.rd2 = 32'h55;
        din.pc = 32'h100; din.imm = 32'hFFFF_FFF8;
        step();
        total++;
        if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF8) begin
            bad++;
            $display("FAIL beq_taken: pcsrc=%b target=%h required 1/000000f8", PCSrcE, PCTargetE);
        end
        din.rd2 = 32'h56;
        step();
        total++;
        if (PCSrcE !== 1'b0) begin
            bad++;
            $display("FAIL beq_not_taken: pcsrc=%b required=0", PCSrcE);
        end
        din.branch = 1'b0; din.jump = 1'b1;
        step();
        total++;
        if (PCSrcE !== 1'b1) begin
            bad++;
            $display("FAIL jump: pcsrc=%b required=1", PCSrcE);
        end
        din.jump = 1'b0; din.rd2 = 32'h55;
        step();
        total++;
        if (PCSrcE !== 1'b0) begin
            bad++;
            $display("FAIL no_branch_equal: pcsrc=%b required=0", PCSrcE);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        din.rw = 1'b1; din.mw = 1'b1; din.rd = 5'd7;
        step();
        din.jump = 1'b1; din.rd = 5'd9;
        FlushE = 1'b1;
        step();
        total++;
        if (PCSrcE !== 1'b0 || RdE !== 5'd0 || RegWriteM !== 1'b1 || RdM !== 5'd7) begin
            bad++;
            $display("FAIL flush_bubble_e: pcsrc=%b rdE=%0d rwM=%b rdM=%0d required 0/0/1/7",
                     PCSrcE, RdE, RegWriteM, RdM);
        end
        clear_inputs();
        step();
        total++;
        if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
            bad++;
            $display("FAIL flush_bubble_m: rw=%b mw=%b required 0/0", RegWriteM, MemWriteM);
        end
    endtask

    task automatic test_back_to_back();
        instr_t       exp_e;
        instr_t       nd;
        mexp_t        exp_m;
        logic [W-1:0] a, wd, b, r, tgt;
        logic         pcsrc;
        clear_inputs();
        FlushE = 1'b1;
        step();
        step();
        exp_e = '0;
        exp_m = '0;
        for (int i = 0; i < 400; i++) begin
            nd        = '0;
            nd.rw     = 1'($urandom);
            nd.mw     = 1'($urandom);
            nd.jump   = ($urandom_range(0, 3) == 0);
            nd.branch = 1'($urandom);
            nd.alusrc = 1'($urandom);
            nd.rsrc   = 2'($urandom);
            nd.aluc   = 3'($urandom);
            nd.rd1    = $urandom;
            nd.rd2    = ($urandom_range(0, 3) == 0) ? nd.rd1 : $urandom;
            nd.imm    = $urandom;
            nd.pc     = $urandom;
            nd.pc4    = $urandom;
            nd.rs1    = 5'($urandom);
            nd.rs2    = 5'($urandom);
            nd.rd     = 5'($urandom);
            din        = nd;
            FlushE     = ($urandom_range(0, 7) == 0);
            ForwardAE  = 2'($urandom);
            ForwardBE  = 2'($urandom);
            ALUResultM = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            ResultW    = $urandom;
            #1;
            a     = fwd_val(ForwardAE, exp_e.rd1, ALUResultM, ResultW);
            wd    = fwd_val(ForwardBE, exp_e.rd2, ALUResultM, ResultW);
            b     = exp_e.alusrc ? exp_e.imm : wd;
            r     = alu_ref(a, b, exp_e.aluc);
            pcsrc = (exp_e.branch && (r == 0)) || exp_e.jump;
            tgt   = exp_e.pc + exp_e.imm;
            total++;
            if (PCSrcE !== pcsrc || PCTargetE !== tgt) begin
                bad++;
                $display("FAIL rnd_redirect cyc=%0d: pcsrc=%b target=%h required %b/%h",
                         i, PCSrcE, PCTargetE, pcsrc, tgt);
            end
            total++;
            if ({Rs1E, Rs2E, RdE, ResultSrcE0} !== {exp_e.rs1, exp_e.rs2, exp_e.rd, exp_e.rsrc[0]}) begin
                bad++;
                $display("FAIL rnd_e_fields cyc=%0d: got=%h required=%h", i,
                         {Rs1E, Rs2E, RdE, ResultSrcE0},
                         {exp_e.rs1, exp_e.rs2, exp_e.rd, exp_e.rsrc[0]});
            end
            total++;
            if ({RegWriteM, MemWriteM, ResultSrcM, ALUResultM_q, WriteDataM, PCPlus4M, RdM} !== exp_m) begin
                bad++;
                $display("FAIL rnd_m_fields cyc=%0d: got=%h required=%h", i,
                         {RegWriteM, MemWriteM, ResultSrcM, ALUResultM_q, WriteDataM, PCPlus4M, RdM},
                         exp_m);
            end
            @(posedge clk);
            #1;
            exp_m = '{rw: exp_e.rw, mw: exp_e.mw, rsrc: exp_e.rsrc, alu: r, wd: wd,
                      pc4: exp_e.pc4, rd: exp_e.rd};
            exp_e = FlushE ? '0 : nd;
        end
    endtask

    initial begin
        test_reset();
        test_alu_codes();
        test_slt_overflow();
        test_forwarding();
        test_branch_jump();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
